// File: rtl/bin2bcd_seq.sv
`default_nettype none
//============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock. Optional two's-complement input gives
//               a sign flag plus BCD magnitude. valid/ready on both sides.
// Revision    : 1.0 - initial release
//============================================================================
module bin2bcd_seq #(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_IN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy
);

    // Number of decimal digits needed by the largest representable magnitude.
    // Five spare bits keep the constant 10 representable even for tiny BIN_W.
    function automatic int f_digits_needed();
        logic [BIN_W+4:0] mag;
        int               n;
        if (SIGNED_IN != 0) begin
            mag = (BIN_W+5)'(1) << (BIN_W-1);
        end else begin
            mag = {5'b0, {BIN_W{1'b1}}};
        end
        n = 0;
        for (int i = 0; i < BIN_W + 1; i++) begin
            if (mag != '0) begin
                mag = mag / (BIN_W+5)'(10);
                n++;
            end
        end
        return n;
    endfunction

    localparam int c_DIGITS_NEEDED = f_digits_needed();
    localparam int c_CNT_W         = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    if (BIN_W < 2) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be at least 2");
    end

    if (c_DIGITS_NEEDED > DIGITS) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for the largest input magnitude");
    end

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic [BIN_W-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_neg;
    logic [4*DIGITS-1:0]   r_out_bcd;
    logic                  r_out_neg;

    logic                  w_is_neg;
    logic [BIN_W-1:0]      w_mag;
    logic [4*DIGITS-1:0]   w_adj;

    // Negative inputs are converted as their magnitude; the most negative
    // value negates onto itself, which is exactly 2**(BIN_W-1) unsigned.
    assign w_is_neg = (SIGNED_IN != 0) && in_bin[BIN_W-1];
    assign w_mag    = w_is_neg ? (~in_bin + 1'b1) : in_bin;

    // Add-3 correction: any digit of 5 or more would exceed 9 after doubling.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                           :  r_bcd[4*k +: 4];
    end

    // Control FSM plus shift datapath; results are published only on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_count   <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_out_bcd <= '0;
            r_out_neg <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_state <= c_S_SHIFT;
                        r_bin   <= w_mag;
                        r_bcd   <= '0;
                        r_neg   <= w_is_neg;
                        r_count <= '0;
                    end
                end
                c_S_SHIFT: begin
                    if (r_count == c_CNT_LAST) begin
                        r_state   <= c_S_DONE;
                        r_out_bcd <= r_bcd;
                        r_out_neg <= r_neg;
                    end else begin
                        // The shift drops the top adjusted bit, which is always
                        // zero because DIGITS covers the largest magnitude.
                        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                        r_count        <= r_count + 1'b1;
                    end
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign busy      = (r_state == c_S_SHIFT);
    assign out_valid = (r_state == c_S_DONE);
    assign out_bcd   = r_out_bcd;
    assign out_neg   = r_out_neg;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Three instances
//               (8-bit unsigned, 16-bit unsigned, 16-bit signed) are checked
//               every cycle against a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [3];
    logic [15:0] in_bin    [3];
    logic        out_ready [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2, ng0, ng1, ng2;
    logic [11:0] bcd0;
    logic [19:0] bcd1, bcd2;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir0),
        .in_bin(in_bin[0][7:0]), .out_valid(ov0), .out_ready(out_ready[0]),
        .out_bcd(bcd0), .out_neg(ng0), .busy(bz0));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(0)) u_d16u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir1),
        .in_bin(in_bin[1]), .out_valid(ov1), .out_ready(out_ready[1]),
        .out_bcd(bcd1), .out_neg(ng1), .busy(bz1));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(1)) u_d16s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir2),
        .in_bin(in_bin[2]), .out_valid(ov2), .out_ready(out_ready[2]),
        .out_bcd(bcd2), .out_neg(ng2), .busy(bz2));

    function automatic int bw_of(int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic rdy(int i);
        return (i == 0) ? ir0 : (i == 1) ? ir1 : ir2;
    endfunction
    function automatic logic ov(int i);
        return (i == 0) ? ov0 : (i == 1) ? ov1 : ov2;
    endfunction
    function automatic logic bz(int i);
        return (i == 0) ? bz0 : (i == 1) ? bz1 : bz2;
    endfunction
    function automatic logic ng(int i);
        return (i == 0) ? ng0 : (i == 1) ? ng1 : ng2;
    endfunction
    function automatic logic [19:0] bcd_of(int i);
        return (i == 0) ? {8'h00, bcd0} : (i == 1) ? bcd1 : bcd2;
    endfunction

    // Reference conversion by decimal arithmetic: returns {neg, bcd}.
    function automatic logic [20:0] ref_conv(int i, logic [15:0] raw);
        int          bw;
        longint      v, mag, p;
        logic        neg;
        logic [19:0] bcd;
        bw  = bw_of(i);
        v   = longint'(raw) & ((longint'(1) << bw) - 1);
        neg = 1'b0;
        if (i == 2 && raw[bw-1]) begin
            neg = 1'b1;
            mag = (longint'(1) << bw) - v;
        end else begin
            mag = v;
        end
        bcd = '0;
        p   = 1;
        for (int d = 0; d < 5; d++) begin
            bcd[4*d +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        return {neg, bcd};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = converting, 2 = result held.
    int          m_st   [3];
    int          m_k    [3];
    logic [19:0] m_bcd  [3];
    logic        m_neg  [3];
    logic [20:0] m_pend [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_st[i]   <= 0;
                m_k[i]    <= 0;
                m_bcd[i]  <= '0;
                m_neg[i]  <= 1'b0;
                m_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (m_st[i])
                    0: if (in_valid[i]) begin
                        m_pend[i] <= ref_conv(i, in_bin[i]);
                        m_st[i]   <= 1;
                        m_k[i]    <= 0;
                    end
                    1: begin
                        m_k[i] <= m_k[i] + 1;
                        if (m_k[i] + 1 == bw_of(i) + 1) begin
                            m_st[i]  <= 2;
                            m_bcd[i] <= m_pend[i][19:0];
                            m_neg[i] <= m_pend[i][20];
                        end
                    end
                    default: if (out_ready[i]) m_st[i] <= 0;
                endcase
            end
        end
    end

    // Every cycle, every instance: handshake, status and held result.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[%0d]", i),  32'(rdy(i)), 32'(m_st[i] == 0));
            chk($sformatf("busy[%0d]", i),      32'(bz(i)),  32'(m_st[i] == 1));
            chk($sformatf("out_valid[%0d]", i), 32'(ov(i)),  32'(m_st[i] == 2));
            chk($sformatf("out_bcd[%0d]", i),   32'(bcd_of(i)), 32'(m_bcd[i]));
            chk($sformatf("out_neg[%0d]", i),   32'(ng(i)),  32'(m_neg[i]));
        end
    end

    // Offer v until accepted; optionally keep in_valid high with junk data
    // for a few cycles afterwards, which the converter must ignore.
    task automatic send(int i, logic [15:0] v, int junk);
        int   n;
        logic r;
        n = 0;
        in_valid[i] = 1'b1;
        in_bin[i]   = v;
        do begin
            r = rdy(i);
            @(posedge clk); #1;
            n++;
        end while (!r && n < 200);
        if (!r) chk("send_timeout", 32'd0, 32'd1);
        repeat (junk) begin
            in_bin[i] = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic recv(int i, int hold, output logic [19:0] bcd, output logic neg,
                        output int lat);
        int n;
        n = 0;
        while (!ov(i) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov(i)) chk("recv_timeout", 32'd0, 32'd1);
        lat = n;
        bcd = bcd_of(i);
        neg = ng(i);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    task automatic xfer(int i, logic [15:0] v, logic [19:0] eb, logic en, string nm);
        logic [19:0] b;
        logic        g;
        int          lat;
        send(i, v, 0);
        recv(i, 0, b, g, lat);
        chk({nm, "_bcd"}, 32'(b), 32'(eb));
        chk({nm, "_neg"}, 32'(g), 32'(en));
        chk({nm, "_lat"}, 32'(lat), 32'(bw_of(i) + 1));
    endtask

    task automatic rand_run(int i, int n);
        logic [19:0] b;
        logic        g;
        int          lat;
        for (int k = 0; k < n; k++) begin
            send(i, 16'($urandom), $urandom_range(0, 3));
            recv(i, $urandom_range(0, 2), b, g, lat);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] b;
        logic        g;
        int          lat;

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_bin[i]    = '0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_bcd", 32'(bcd_of(2)), 32'd0);
        chk("rst_ready", 32'(rdy(0)), 32'd1);

        // Literal anchors for the reference model itself.
        chk("model_255",   32'(ref_conv(0, 16'd255)),   32'h000255);
        chk("model_8000",  32'(ref_conv(2, 16'h8000)),  32'h132768);
        chk("model_ffffu", 32'(ref_conv(1, 16'hFFFF)),  32'h065535);

        // 8-bit: zero, full scale, then full sweep with random pacing.
        xfer(0, 16'd0,   20'h00000, 1'b0, "t1_zero");
        xfer(0, 16'd255, 20'h00255, 1'b0, "t2_255");
        for (int v = 1; v < 255; v++) begin
            send(0, 16'(v), $urandom_range(0, 3));
            recv(0, $urandom_range(0, 2), b, g, lat);
        end

        // 16-bit unsigned.
        xfer(1, 16'd65535, 20'h65535, 1'b0, "t3_65535");
        xfer(1, 16'd10000, 20'h10000, 1'b0, "t3_10000");
        rand_run(1, 150);

        // 16-bit signed.
        xfer(2, 16'h8000, 20'h32768, 1'b1, "t4_8000");
        xfer(2, 16'hFFFF, 20'h00001, 1'b1, "t4_ffff");
        xfer(2, 16'h7FFF, 20'h32767, 1'b0, "t4_7fff");
        xfer(2, 16'h0000, 20'h00000, 1'b0, "t4_zero");
        rand_run(2, 150);

        // Back-pressure for 20 cycles in DONE.
        send(2, 16'd4321, 0);
        recv(2, 20, b, g, lat);
        chk("t5_bcd", 32'(b), 32'h04321);
        chk("t5_ready_after", 32'(rdy(2)), 32'd1);

        // Reset after the fifth shift discards the conversion.
        send(2, 16'd999, 0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ov(2)), 32'd0);
        chk("t6_rst_busy",  32'(bz(2)), 32'd0);
        chk("t6_rst_bcd",   32'(bcd_of(2)), 32'd0);
        chk("t6_rst_ready", 32'(rdy(2)), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(2, 16'd1234, 20'h01234, 1'b0, "t6_1234");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
